// File: rtl/dispensador_cambio_if.sv
// Handshake and payout bundle between the control FSM and the change dispenser.
interface dispensador_cambio_if #(parameter int WIDTH = 4);
  logic             start;
  logic             refund;
  logic [WIDTH-1:0] monto;
  logic [WIDTH-1:0] costo;
  logic [2:0]       coin_out;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] coin_count;

  modport master (output start, refund, monto, costo,
                  input  coin_out, busy, done, err, coin_count);
  modport slave  (input  start, refund, monto, costo,
                  output coin_out, busy, done, err, coin_count);
endinterface

// File: rtl/dispensador_cambio.sv
// Change/refund dispenser: greedy coin selection, paid out as timed one-hot eject pulses.
module dispensador_cambio #(
  parameter int WIDTH        = 4,
  parameter int DEN_HI       = 4,
  parameter int DEN_MID      = 2,
  parameter int DEN_LO       = 1,
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 1
) (
  input  logic              clk,
  input  logic              rst,
  dispensador_cambio_if.slave bus
);
  localparam int TMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [1:0] {IDLE, PULSE, GAP, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d, cnt_q, cnt_d, den_val;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [2:0]       den_q, den_d, coin_q, coin_d;
  logic             err_q, err_d, busy_q, busy_d, done_q, done_d;

  function automatic logic [2:0] pick(input logic [WIDTH-1:0] r);
    if (r >= WIDTH'(DEN_HI))       return 3'b100;
    else if (r >= WIDTH'(DEN_MID)) return 3'b010;
    else                           return 3'b001;
  endfunction

  always_comb begin
    case (den_q)
      3'b100:  den_val = WIDTH'(DEN_HI);
      3'b010:  den_val = WIDTH'(DEN_MID);
      default: den_val = WIDTH'(DEN_LO);
    endcase
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    den_d   = den_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        if (bus.refund || (bus.monto >= bus.costo)) begin
          rem_d = bus.refund ? bus.monto : (bus.monto - bus.costo);
          cnt_d = '0;
          tmr_d = '0;
          if (rem_d == '0) state_d = DONE;
          else begin
            state_d = PULSE;
            den_d   = pick(rem_d);
          end
        end else begin
          err_d = 1'b1;
        end
      end
      PULSE: if (tmr_q == TW'(PULSE_CYCLES - 1)) begin
        rem_d   = rem_q - den_val;
        cnt_d   = cnt_q + 1'b1;
        tmr_d   = '0;
        state_d = GAP;
      end else begin
        tmr_d = tmr_q + 1'b1;
      end
      GAP: if (tmr_q == TW'(GAP_CYCLES - 1)) begin
        tmr_d = '0;
        if (rem_q != '0) begin
          state_d = PULSE;
          den_d   = pick(rem_q);
        end else begin
          state_d = DONE;
        end
      end else begin
        tmr_d = tmr_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are decoded from the next state so they line up with it once registered.
    coin_d = (state_d == PULSE) ? den_d : 3'b000;
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      cnt_q   <= '0;
      tmr_q   <= '0;
      den_q   <= 3'b000;
      coin_q  <= 3'b000;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      den_q   <= den_d;
      coin_q  <= coin_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.coin_out   = coin_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.coin_count = cnt_q;
endmodule

// File: tb/tb_dispensador_cambio.sv
// Directed + random bench for the change dispenser, checked against a coin-list reference model.
module tb_dispensador_cambio;
  localparam int W = 4, PC = 2, GC = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   model_cnt = 0;

  typedef struct {
    logic [2:0] coin;
    logic       busy;
    logic       done;
    logic       err;
    int         cnt;
  } exp_t;
  exp_t q[$];

  dispensador_cambio_if #(.WIDTH(W)) bus();

  dispensador_cambio #(.WIDTH(W), .DEN_HI(4), .DEN_MID(2), .DEN_LO(1),
                       .PULSE_CYCLES(PC), .GAP_CYCLES(GC))
    dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_cyc(input string tag, input exp_t e);
    chk({tag, ".coin"}, 32'(bus.coin_out), 32'(e.coin));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(e.busy));
    chk({tag, ".done"}, 32'(bus.done), 32'(e.done));
    chk({tag, ".err"},  32'(bus.err),  32'(e.err));
    chk({tag, ".cnt"},  32'(bus.coin_count), 32'(e.cnt));
    chk({tag, ".onehot"}, 32'($countones(bus.coin_out) <= 1), 32'd1);
  endtask

  // Reference: list the greedy coins, then expand each into pulse and gap cycles.
  task automatic build(input int m, input int c, input int r);
    int ch, d, n;
    logic [2:0] oh;
    q.delete();
    if (r == 0 && m < c) begin
      q.push_back('{3'b000, 1'b0, 1'b0, 1'b1, model_cnt});
      return;
    end
    ch = (r != 0) ? m : m - c;
    n  = 0;
    while (ch > 0) begin
      d  = (ch >= 4) ? 4 : (ch >= 2) ? 2 : 1;
      oh = (d == 4) ? 3'b100 : (d == 2) ? 3'b010 : 3'b001;
      for (int p = 0; p < PC; p++) q.push_back('{oh, 1'b1, 1'b0, 1'b0, n});
      ch -= d;
      n++;
      for (int g = 0; g < GC; g++) q.push_back('{3'b000, 1'b1, 1'b0, 1'b0, n});
    end
    q.push_back('{3'b000, 1'b1, 1'b1, 1'b0, n});
    model_cnt = n;
  endtask

  // inject_at: cycle index at which a stray start is pulsed; rst_at: cycle index to reset in.
  task automatic dispense(input string tag, input int m, input int c, input int r,
                          input int inject_at, input int rst_at);
    exp_t idle_e;
    int   n;
    build(m, c, r);
    n = q.size();
    @(negedge clk);
    bus.start  = 1'b1;
    bus.monto  = W'(m);
    bus.costo  = W'(c);
    bus.refund = r[0];
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus.start = 1'b0;
        bus.monto = W'($urandom_range(0, 15));
        bus.costo = W'($urandom_range(0, 15));
      end
      if (i == inject_at + 1) bus.start = 1'b0;
      chk_cyc($sformatf("%s.c%0d", tag, i + 1), q[i]);
      if (i == inject_at) begin
        bus.start  = 1'b1;
        bus.monto  = 4'd15;
        bus.refund = 1'b1;
      end
      if (i == rst_at) begin
        #2 rst = 1'b0;
        #1;
        model_cnt = 0;
        chk_cyc({tag, ".rst_async"}, '{3'b000, 1'b0, 1'b0, 1'b0, 0});
        @(negedge clk);
        rst = 1'b1;
        break;
      end
    end
    bus.start = 1'b0;
    idle_e = '{3'b000, 1'b0, 1'b0, 1'b0, model_cnt};
    for (int k = 0; k < ((rst_at >= 0) ? 6 : 1); k++) begin
      @(negedge clk);
      chk_cyc($sformatf("%s.idle%0d", tag, k), idle_e);
    end
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.refund = 1'b0;
    bus.monto  = '0;
    bus.costo  = '0;
    #12;
    chk_cyc("reset", '{3'b000, 1'b0, 1'b0, 1'b0, 0});
    rst = 1'b1;
    @(negedge clk);
    chk_cyc("post_reset", '{3'b000, 1'b0, 1'b0, 1'b0, 0});

    dispense("s1_change7",  11, 4, 0, -1, -1);
    dispense("s4_err",       3, 5, 0, -1, -1);
    dispense("s2_refund15", 15, 9, 1, -1, -1);
    dispense("s3_exact",     6, 6, 0, -1, -1);
    dispense("s5_ignore",   11, 4, 0,  2, -1);
    dispense("s6_rst",       7, 0, 0, -1,  3);
    dispense("edge_max",    15, 0, 0, -1, -1);
    dispense("edge_one",     1, 0, 0, -1, -1);
    dispense("edge_refund0", 0, 7, 1, -1, -1);

    for (int t = 0; t < 25; t++) begin
      int m, c, r;
      m = $urandom_range(0, 15);
      c = $urandom_range(0, 15);
      r = ($urandom_range(0, 3) == 0) ? 1 : 0;
      dispense($sformatf("rnd%0d", t), m, c, r, -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
